// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and field layout for the debug trace buffer.
//                Serializer state encoding, trace record field offsets and
//                the bit positions used in the second output beat.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } ser_state_e;

  localparam int OPC_W      = 6;
  localparam int RA_W       = 5;

  // Beat 1 layout: {opcode[31:26], wr_addr[25:21], 5'b0, seq[15:0]}
  localparam int B1_OPC_LSB = 26;
  localparam int B1_RA_LSB  = 21;
  localparam int B1_SEQ_W   = 16;

  // Record layout, LSB first: seq | wr_data | wr_addr | opcode | pc
  function automatic int record_w(input int ws, input int cw);
    return 2 * ws + OPC_W + RA_W + cw;
  endfunction

  function automatic int data_lsb(input int cw);
    return cw;
  endfunction

  function automatic int ra_lsb(input int ws, input int cw);
    return cw + ws;
  endfunction

  function automatic int opc_lsb(input int ws, input int cw);
    return cw + ws + RA_W;
  endfunction

  function automatic int pc_lsb(input int ws, input int cw);
    return cw + ws + RA_W + OPC_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Synchronous FIFO with first-word fall-through read data.
//                A push into a full FIFO is accepted when a pop happens in
//                the same cycle. flush empties the FIFO.
//  Ports       : clk, rst (sync, active-low), flush_i, push_i, pop_i,
//                wdata_i, rdata_o (head), full_o, empty_o, count_o
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_pop_ok;
  logic             w_push_ok;

  // Extra MSB on each pointer distinguishes full from empty.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  assign w_pop_ok  = pop_i && !empty_o && !flush_i;
  // When full, the slot being written is the head being popped; the pop
  // reads the old contents before the write lands at the same edge.
  assign w_push_ok = push_i && (!full_o || w_pop_ok) && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/debug_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_trace_buffer
//  Description : Captures one trace record per new processor pc into a FIFO
//                and streams each record as three beats (pc, {op,ra,seq},
//                wr_data) over valid/ready. Records arriving while full are
//                dropped, counted and flagged.
//  Ports       : clk, rst (sync, active-low), capture_en, flush,
//                prog_count/instr_opcode/write_reg_addr/write_reg_data (in),
//                out_data/out_valid/out_last (out), out_ready (in),
//                fifo_count, overflow, drop_count (status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_trace_buffer
  import trace_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic                   flush,
  input  logic [WORD_SIZE-1:0]   prog_count,
  input  logic [5:0]             instr_opcode,
  input  logic [4:0]             write_reg_addr,
  input  logic [WORD_SIZE-1:0]   write_reg_data,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int RECORD_W = record_w(WORD_SIZE, CNT_W);
  localparam int DATA_LSB = data_lsb(CNT_W);
  localparam int RA_LSB   = ra_lsb(WORD_SIZE, CNT_W);
  localparam int OPC_LSB  = opc_lsb(WORD_SIZE, CNT_W);
  localparam int PC_LSB   = pc_lsb(WORD_SIZE, CNT_W);

  ser_state_e            state_q, state_d;
  logic [RECORD_W-1:0]   hold_q;
  logic [WORD_SIZE-1:0]  last_pc_q;
  logic                  first_q;
  logic [CNT_W-1:0]      seq_q;
  logic                  overflow_q;
  logic [CNT_W-1:0]      drop_count_q;

  logic [RECORD_W-1:0]   w_rec;
  logic [RECORD_W-1:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_drop;
  logic [WORD_SIZE-1:0]  w_b1;

  // Flush discards any capture in the same cycle.
  assign w_capture = capture_en && !flush && (first_q || (prog_count != last_pc_q));
  assign w_drop    = w_capture && w_full && !w_pop;
  assign w_rec     = {prog_count, instr_opcode, write_reg_addr, write_reg_data, seq_q};

  trace_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (w_capture),
    .pop_i   (w_pop),
    .wdata_i (w_rec),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    w_b1 = '0;
    w_b1[B1_OPC_LSB +: OPC_W] = hold_q[OPC_LSB +: OPC_W];
    w_b1[B1_RA_LSB  +: RA_W]  = hold_q[RA_LSB  +: RA_W];
    w_b1[0 +: B1_SEQ_W]       = B1_SEQ_W'(hold_q[0 +: CNT_W]);
  end

  // Serializer next-state and beat outputs.
  always_comb begin
    state_d   = state_q;
    w_pop     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = S_B0;
        end
      end
      S_B0: begin
        out_valid = 1'b1;
        out_data  = hold_q[PC_LSB +: WORD_SIZE];
        if (out_ready) state_d = S_B1;
      end
      S_B1: begin
        out_valid = 1'b1;
        out_data  = w_b1;
        if (out_ready) state_d = S_B2;
      end
      S_B2: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = hold_q[DATA_LSB +: WORD_SIZE];
        if (out_ready) begin
          // Chain straight into the next record with no idle bubble.
          if (!w_empty) begin
            w_pop   = 1'b1;
            state_d = S_B0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      w_pop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      last_pc_q    <= '0;
      first_q      <= 1'b1;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_pop) hold_q <= w_head;
      if (flush) begin
        overflow_q   <= 1'b0;
        drop_count_q <= '0;
      end else begin
        // seq advances on drops too so downstream sees the gap.
        if (w_capture) begin
          last_pc_q <= prog_count;
          first_q   <= 1'b0;
          seq_q     <= seq_q + CNT_W'(1);
        end
        if (w_drop) begin
          overflow_q <= 1'b1;
          if (drop_count_q != '1) drop_count_q <= drop_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire
